// File: rtl/pwl_pkg.sv
// Shared types and helpers for the piecewise-linear activation pipeline.
// Mode encodings, segment entry layout at default widths, and saturation helpers.
package pwl_pkg;

  localparam int PWL_DATA_W = 16;
  localparam int PWL_COEF_W = 16;

  typedef enum logic [1:0] {
    PWL_PLAIN = 2'd0,
    PWL_ODD   = 2'd1,
    PWL_SIG   = 2'd2,
    PWL_RSVD  = 2'd3
  } pwl_mode_e;

  typedef struct packed {
    logic signed [PWL_DATA_W-1:0] bkpt;
    logic signed [PWL_COEF_W-1:0] slope;
    logic signed [PWL_DATA_W-1:0] bias;
  } pwl_seg_t;

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] pwl_sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pwl_seg_select.sv
// Comparator bank plus priority encoder: picks the highest segment whose
// lower breakpoint is <= xe, falling back to segment 0.
module pwl_seg_select
  import pwl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SEG_N  = 16
) (
  input  logic signed [DATA_W-1:0]             xe,
  input  logic        [SEG_N-1:0][DATA_W-1:0]  bkpt_vec,
  output logic        [$clog2(SEG_N)-1:0]      idx
);

  localparam int IDX_W = $clog2(SEG_N);

  always_comb begin
    idx = '0;
    for (int i = 0; i < SEG_N; i++) begin
      if (xe >= $signed(bkpt_vec[i])) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pwl_act_pipe.sv
// Three-stage pipelined piecewise-linear activation with a programmable segment
// table, per-sample symmetry mode and a global-stall valid/ready handshake.
module pwl_act_pipe
  import pwl_pkg::*;
#(
  parameter int DATA_W = PWL_DATA_W,
  parameter int FRAC_W = 8,
  parameter int COEF_W = PWL_COEF_W,
  parameter int SEG_N  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_W-1:0]     in_x,
  input  logic        [1:0]            in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_W-1:0]     out_y,
  output logic                         out_sat,
  input  logic                         cfg_we,
  input  logic [$clog2(SEG_N)-1:0]     cfg_addr,
  input  logic signed [DATA_W-1:0]     cfg_bkpt,
  input  logic signed [COEF_W-1:0]     cfg_slope,
  input  logic signed [DATA_W-1:0]     cfg_bias
);

  localparam int IDX_W = $clog2(SEG_N);
  localparam int PW    = DATA_W + 1 + COEF_W;
  localparam int SW    = PW + 1;
  localparam logic signed [DATA_W-1:0] X_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] X_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  typedef struct packed {
    logic signed [DATA_W-1:0] bkpt;
    logic signed [COEF_W-1:0] slope;
    logic signed [DATA_W-1:0] bias;
  } seg_t;

  seg_t tbl_q [SEG_N];
  seg_t tbl_d [SEG_N];

  logic                      s1_valid_q, s1_valid_d;
  logic signed [DATA_W-1:0]  s1_xe_q, s1_xe_d;
  seg_t                      s1_seg_q, s1_seg_d;
  pwl_mode_e                 s1_mode_q, s1_mode_d;
  logic                      s1_neg_q, s1_neg_d;

  logic                      s2_valid_q, s2_valid_d;
  logic signed [PW-1:0]      s2_p_q, s2_p_d;
  logic signed [DATA_W-1:0]  s2_bias_q, s2_bias_d;
  pwl_mode_e                 s2_mode_q, s2_mode_d;
  logic                      s2_neg_q, s2_neg_d;

  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_y_q, out_y_d;
  logic                      out_sat_q, out_sat_d;

  logic stall;
  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_sat   = out_sat_q;

  // Stage 1: fold input for symmetric modes and look up its segment.
  pwl_mode_e                        mode_in;
  logic                             sym;
  logic signed [DATA_W-1:0]         xe;
  logic [SEG_N-1:0][DATA_W-1:0]     bkpt_vec;
  logic [IDX_W-1:0]                 sel_idx;
  seg_t                             sel_seg;

  always_comb begin
    mode_in = PWL_PLAIN;
    if (in_mode == PWL_ODD || in_mode == PWL_SIG) mode_in = pwl_mode_e'(in_mode);
    sym = (mode_in != PWL_PLAIN);
    xe  = in_x;
    if (sym) begin
      if (in_x == X_MIN)      xe = X_MAX;
      else if (in_x[DATA_W-1]) xe = -in_x;
    end
    for (int i = 0; i < SEG_N; i++) bkpt_vec[i] = tbl_q[i].bkpt;
  end

  pwl_seg_select #(
    .DATA_W (DATA_W),
    .SEG_N  (SEG_N)
  ) u_seg_select (
    .xe       (xe),
    .bkpt_vec (bkpt_vec),
    .idx      (sel_idx)
  );

  assign sel_seg = tbl_q[sel_idx];

  // Stage 2: offset from breakpoint times slope, floor-scaled back to FRAC_W.
  logic signed [DATA_W:0]  d;
  logic signed [PW-1:0]    d_ext;
  logic signed [PW-1:0]    slope_ext;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    p_sh;

  always_comb begin
    d         = {s1_xe_q[DATA_W-1], s1_xe_q} - {s1_seg_q.bkpt[DATA_W-1], s1_seg_q.bkpt};
    d_ext     = {{COEF_W{d[DATA_W]}}, d};
    slope_ext = {{(DATA_W+1){s1_seg_q.slope[COEF_W-1]}}, s1_seg_q.slope};
    prod      = d_ext * slope_ext;
    p_sh      = prod >>> FRAC_W;
  end

  // Stage 3: add bias, saturate, apply symmetry, saturate again.
  logic signed [SW-1:0]      sum;
  logic signed [63:0]        sum64, s64, s_ext, t64, y64;
  logic signed [DATA_W-1:0]  s_w;
  logic                      clip1, clip2;

  always_comb begin
    sum   = {s2_p_q[PW-1], s2_p_q} + {{(SW-DATA_W){s2_bias_q[DATA_W-1]}}, s2_bias_q};
    sum64 = {{(64-SW){sum[SW-1]}}, sum};
    s64   = pwl_sat(sum64, DATA_W);
    clip1 = (s64 != sum64);
    s_w   = s64[DATA_W-1:0];
    s_ext = {{(64-DATA_W){s_w[DATA_W-1]}}, s_w};
    t64   = s_ext;
    if (s2_neg_q && s2_mode_q == PWL_ODD) t64 = -s_ext;
    if (s2_neg_q && s2_mode_q == PWL_SIG) t64 = (64'sd1 <<< FRAC_W) - s_ext;
    y64   = pwl_sat(t64, DATA_W);
    clip2 = (y64 != t64);
  end

  always_comb begin
    tbl_d       = tbl_q;
    s1_valid_d  = s1_valid_q;
    s1_xe_d     = s1_xe_q;
    s1_seg_d    = s1_seg_q;
    s1_mode_d   = s1_mode_q;
    s1_neg_d    = s1_neg_q;
    s2_valid_d  = s2_valid_q;
    s2_p_d      = s2_p_q;
    s2_bias_d   = s2_bias_q;
    s2_mode_d   = s2_mode_q;
    s2_neg_d    = s2_neg_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_sat_d   = out_sat_q;

    // Table writes ignore stall; the current-cycle lookup still sees old contents.
    if (cfg_we) begin
      tbl_d[cfg_addr].bkpt  = cfg_bkpt;
      tbl_d[cfg_addr].slope = cfg_slope;
      tbl_d[cfg_addr].bias  = cfg_bias;
    end

    if (!stall) begin
      s1_valid_d  = in_valid;
      s1_xe_d     = xe;
      s1_seg_d    = sel_seg;
      s1_mode_d   = mode_in;
      s1_neg_d    = sym & in_x[DATA_W-1];
      s2_valid_d  = s1_valid_q;
      s2_p_d      = p_sh;
      s2_bias_d   = s1_seg_q.bias;
      s2_mode_d   = s1_mode_q;
      s2_neg_d    = s1_neg_q;
      out_valid_d = s2_valid_q;
      out_y_d     = y64[DATA_W-1:0];
      out_sat_d   = clip1 | clip2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEG_N; i++) tbl_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_xe_q     <= '0;
      s1_seg_q    <= '0;
      s1_mode_q   <= PWL_PLAIN;
      s1_neg_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_p_q      <= '0;
      s2_bias_q   <= '0;
      s2_mode_q   <= PWL_PLAIN;
      s2_neg_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      tbl_q       <= tbl_d;
      s1_valid_q  <= s1_valid_d;
      s1_xe_q     <= s1_xe_d;
      s1_seg_q    <= s1_seg_d;
      s1_mode_q   <= s1_mode_d;
      s1_neg_q    <= s1_neg_d;
      s2_valid_q  <= s2_valid_d;
      s2_p_q      <= s2_p_d;
      s2_bias_q   <= s2_bias_d;
      s2_mode_q   <= s2_mode_d;
      s2_neg_q    <= s2_neg_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Self-checking bench for pwl_act_pipe: directed table/mode/stall/reset steps
// plus a randomized phase, all checked against an arithmetic reference model.
module tb_pwl_act_pipe;

  localparam int DW    = 16;
  localparam int SEG   = 16;
  localparam int SCALE = 256;
  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [DW-1:0] in_x = '0;
  logic [1:0]        in_mode = 2'd0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [DW-1:0] out_y;
  logic              out_sat;
  logic              cfg_we = 1'b0;
  logic [3:0]        cfg_addr = '0;
  logic signed [DW-1:0] cfg_bkpt = '0;
  logic signed [15:0]   cfg_slope = '0;
  logic signed [DW-1:0] cfg_bias = '0;

  pwl_act_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bkpt(cfg_bkpt),
    .cfg_slope(cfg_slope), .cfg_bias(cfg_bias)
  );

  always #5 clk = ~clk;

  typedef struct { int y; bit sat; int cyc; } res_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_lat = -1;
  int   stall_seen = 0;
  bit   acc_flag;
  bit   hold_chk = 0;
  int   held_y;
  bit   held_sat;
  res_t exp_q[$];
  res_t obs_q[$];
  int   bk[SEG], sl[SEG], bi[SEG];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, inout bit sat);
    if (v > MAXV) begin sat = 1; return MAXV; end
    if (v < MINV) begin sat = 1; return MINV; end
    return v;
  endfunction

  // Reference: fold, pick segment, linear interpolation, saturate, mirror.
  function automatic void ref_eval(input int x, input int mode, output int y, output bit sat);
    int m, idx;
    bit neg;
    longint xe, p, ps, s, t;
    m   = (mode == 3) ? 0 : mode;
    neg = (m != 0) && (x < 0);
    xe  = x;
    if (neg) xe = -longint'(x);
    if (xe > MAXV) xe = MAXV;
    idx = 0;
    for (int i = 0; i < SEG; i++) if (xe >= bk[i]) idx = i;
    p  = (xe - bk[idx]) * sl[idx];
    ps = p / SCALE;
    if (p < 0 && (p % SCALE) != 0) ps = ps - 1;
    sat = 0;
    s = clamp(ps + bi[idx], sat);
    if (!neg)        t = s;
    else if (m == 1) t = -s;
    else             t = SCALE - s;
    t = clamp(t, sat);
    y = int'(t) & 32'hFFFF;
  endfunction

  task automatic step();
    res_t r;
    int ry;
    bit rs;
    @(negedge clk);
    acc_flag = 0;
    if (rst) begin
      exp_q.delete();
      hold_chk = 0;
      for (int i = 0; i < SEG; i++) begin bk[i] = 0; sl[i] = 0; bi[i] = 0; end
    end else begin
      if (hold_chk) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_y", int'(out_y) & 32'hFFFF, held_y);
        chk("stall_hold_sat", out_sat, held_sat);
      end
      hold_chk = 0;
      if (out_valid && !out_ready) begin
        chk("in_ready_stall", in_ready, 0);
        stall_seen++;
        hold_chk = 1;
        held_y   = int'(out_y) & 32'hFFFF;
        held_sat = out_sat;
      end
      if (in_valid && in_ready) begin
        ref_eval(int'(in_x), int'(in_mode), ry, rs);
        r.y = ry; r.sat = rs; r.cyc = cyc;
        exp_q.push_back(r);
        acc_flag = 1;
      end
      if (out_valid && out_ready) begin
        chk("no_spurious_out", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("out_y", int'(out_y) & 32'hFFFF, r.y);
          chk("out_sat", out_sat, r.sat);
          last_lat = cyc - r.cyc;
          r.y = int'(out_y) & 32'hFFFF; r.sat = out_sat;
          obs_q.push_back(r);
        end
      end
      if (cfg_we) begin
        bk[cfg_addr] = int'(cfg_bkpt);
        sl[cfg_addr] = int'(cfg_slope);
        bi[cfg_addr] = int'(cfg_bias);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input int a, input int b, input int s, input int bb);
    cfg_we = 1; cfg_addr = 4'(a); cfg_bkpt = 16'(b); cfg_slope = 16'(s); cfg_bias = 16'(bb);
    step();
    cfg_we = 0;
  endtask

  task automatic send(input int x, input int mode);
    in_valid = 1; in_x = 16'(x); in_mode = 2'(mode);
    step();
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid  = 0;
    out_ready = 1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic expect_out(input string tag, input int y, input bit sat);
    res_t o;
    chk({tag, "_present"}, obs_q.size() > 0, 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, "_y"}, o.y, y);
      chk({tag, "_sat"}, o.sat, sat);
    end
  endtask

  task automatic single(input string tag, input int x, input int mode, input int y, input bit sat);
    obs_q.delete();
    send(x, mode);
    drain();
    expect_out(tag, y, sat);
  endtask

  initial begin
    int vals[8];
    int i, k, n_out;

    for (int j = 0; j < SEG; j++) begin bk[j] = 0; sl[j] = 0; bi[j] = 0; end
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    single("rst_table_zero", 'h1234, 0, 'h0000, 0);

    cfg_write(0, -32768, 0, 0);
    cfg_write(1, 'h0000, 'h0040, 'h0080);
    cfg_write(2, 'h0200, 0, 'h00F0);
    for (int a = 3; a < SEG; a++) cfg_write(a, 'h7FFF, 0, 'h00F0);

    single("m0_pos", 'h0100, 0, 'h00C0, 0);
    chk("latency", last_lat, 3);
    single("m0_neg", -'h0100, 0, 'h0000, 0);
    single("m2_neg", -'h0100, 2, 'h0040, 0);
    single("m1_neg", -'h0100, 1, 'hFF40, 0);
    single("m1_min", -'h8000, 1, 'hFF10, 0);
    single("m3_as_plain", 'h0100, 3, 'h00C0, 0);
    single("m0_seg2", 'h0300, 0, 'h00F0, 0);

    // Write and accept in the same cycle: sample must see the old seg1.
    obs_q.delete();
    cfg_we = 1; cfg_addr = 4'd1; cfg_bkpt = 16'h0000; cfg_slope = 16'h7FFF; cfg_bias = 16'h7000;
    in_valid = 1; in_x = 16'h0100; in_mode = 2'd0;
    step();
    cfg_we = 0;
    in_x = 16'h01FF;
    step();
    drain();
    expect_out("write_cycle_old", 'h00C0, 0);
    expect_out("new_seg1_sat", 'h7FFF, 1);

    // Stream 8 samples with a 5-cycle downstream stall in the middle.
    obs_q.delete();
    stall_seen = 0;
    for (int j = 0; j < 8; j++) vals[j] = j * 'h10;
    i = 0; k = 0;
    while (i < 8 && k < 60) begin
      out_ready = !(k >= 4 && k < 9);
      in_valid  = 1; in_x = 16'(vals[i]); in_mode = 2'd0;
      step();
      if (acc_flag) i++;
      k++;
    end
    chk("stream_accepted", i, 8);
    drain();
    chk("stall_seen", stall_seen, 5);
    n_out = obs_q.size();
    chk("stream_count", n_out, 8);
    for (int j = 0; j < 8 && j < n_out; j++) begin
      int ry; bit rs;
      ref_eval(vals[j], 0, ry, rs);
      chk("stream_order", obs_q[j].y, ry);
    end

    // Randomized traffic, backpressure and table rewrites.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom % 4) != 0;
      in_x      = 16'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom % 4) != 0;
      cfg_we    = ($urandom % 12) == 0;
      cfg_addr  = 4'($urandom);
      cfg_bkpt  = 16'($urandom);
      cfg_slope = 16'($urandom);
      cfg_bias  = 16'($urandom);
      step();
    end
    cfg_we = 0;
    drain();

    // Reset with three samples in flight.
    obs_q.delete();
    send(1, 0); send(2, 1); send(3, 2);
    out_ready = 0;
    rst = 1;
    step();
    rst = 0;
    out_ready = 1;
    chk("midrst_out_valid", out_valid, 0);
    for (int j = 0; j < 5; j++) step();
    chk("midrst_no_stale", obs_q.size(), 0);
    single("post_rst_zero_m0", 'h5A5A, 0, 'h0000, 0);
    single("post_rst_zero_m1", -'h3000, 1, 'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
